// File: rtl/uart_rx_word_pkg.sv
// Shared definitions for the UART receive path: clock constants, baud
// defaults and the receiver FSM state encoding (same encoding as the Tx).
package uart_rx_word_pkg;

  localparam int CLK_FREQ_HZ      = 100_000_000;
  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int DEF_TIMEOUT_BITS = 20;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

  // Clocks to wait after start detect so the start bit is sampled mid-bit.
  function automatic int mid_bit_wait(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_word_if.sv
// Host-facing bundle of the word receiver.
// Handshake: there is no back-pressure. Byte_Valid, Rx_Valid, Frame_Err and
// Sync_Err are single-clock strobes with no ready; the consumer must take
// Rx_Byte/Rx_Data in the clock its strobe is high (the values also hold until
// the next update). Rx_Valid only ever fires together with Byte_Valid.
interface uart_rx_word_if;
  logic        Rx_Serial;
  logic [7:0]  Rx_Byte;
  logic        Byte_Valid;
  logic [15:0] Rx_Data;
  logic        Rx_Valid;
  logic        Frame_Err;
  logic        Sync_Err;
  logic        Busy;

  // Line driver / result consumer side.
  modport master (
    output Rx_Serial,
    input  Rx_Byte, Byte_Valid, Rx_Data, Rx_Valid, Frame_Err, Sync_Err, Busy
  );

  // Receiver side.
  modport slave (
    input  Rx_Serial,
    output Rx_Byte, Byte_Valid, Rx_Data, Rx_Valid, Frame_Err, Sync_Err, Busy
  );
endinterface

// File: rtl/uart_rx_word_byte.sv
// Byte receiver: 2-flop input synchroniser plus 8N1 bit FSM. Produces the
// registered byte outputs and combinational strobes the word layer uses.
module uart_rx_word_byte
  import uart_rx_word_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial_i,
  output logic [7:0] rx_byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o,
  output logic       busy_o,
  output logic       idle_o,
  output logic       start_det_o,
  output logic       good_stb_o,
  output logic       bad_stb_o,
  output logic [7:0] shift_o,
  output rx_state_e  state_o
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_WAIT = BW'(mid_bit_wait(CLKS_PER_BIT));

  logic            sync1_q, sync2_q;
  rx_state_e       state_q, state_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_byte_q;
  logic            byte_valid_q;
  logic            frame_err_q;
  logic            line;
  logic            good_stb;
  logic            bad_stb;
  logic            start_det;
  logic            idle;

  assign line = sync2_q;

  // Two-flop synchroniser, preset to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_serial_i;
      sync2_q <= sync1_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state plus baud counter, bit index and shift register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!line) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_WAIT) begin
          cnt_d   = '0;
          state_d = line ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d   = '0;
          shift_d = {line, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d   = '0;
          state_d = line ? ST_IDLE : ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        cnt_d = '0;
        if (line) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore/Mealy outputs decoded from the current state and sampled line.
  always_comb begin
    idle      = (state_q == ST_IDLE);
    start_det = idle && !line;
    good_stb  = (state_q == ST_STOP) && (cnt_q == BAUD_LAST) && line;
    bad_stb   = (state_q == ST_STOP) && (cnt_q == BAUD_LAST) && !line;
  end

  // Datapath registers and registered result strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= good_stb;
      frame_err_q  <= bad_stb;
      if (good_stb) rx_byte_q <= shift_q;
    end
  end

  assign rx_byte_o    = rx_byte_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;
  assign busy_o       = !idle;
  assign idle_o       = idle;
  assign start_det_o  = start_det;
  assign good_stb_o   = good_stb;
  assign bad_stb_o    = bad_stb;
  assign shift_o      = shift_q;
  assign state_o      = state_q;

endmodule

// File: rtl/uart_rx_word.sv
// Word receiver: pairs consecutive good bytes into {high,low} words and drops
// a lone high byte if the low byte does not start within the timeout.
module uart_rx_word
  import uart_rx_word_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_word_if.slave   bus,
  output rx_state_e       dbg_state_o
);

  localparam int TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW        = $clog2(TMO_LIMIT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TMO_LIMIT);

  logic [7:0]  rx_byte;
  logic        byte_valid;
  logic        frame_err;
  logic        busy;
  logic        idle;
  logic        start_det;
  logic        good_stb;
  logic        bad_stb;
  logic [7:0]  shift;
  rx_state_e   state;

  logic          ptr_q, ptr_d;
  logic [7:0]    high_q, high_d;
  logic [15:0]   data_q, data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          sync_err_q, sync_err_d;
  logic [TW-1:0] tmo_q, tmo_d;

  uart_rx_word_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk          (clk),
    .rst          (rst),
    .rx_serial_i  (bus.Rx_Serial),
    .rx_byte_o    (rx_byte),
    .byte_valid_o (byte_valid),
    .frame_err_o  (frame_err),
    .busy_o       (busy),
    .idle_o       (idle),
    .start_det_o  (start_det),
    .good_stb_o   (good_stb),
    .bad_stb_o    (bad_stb),
    .shift_o      (shift),
    .state_o      (state)
  );

  // Byte pairing and inter-byte timeout. Good bytes and timeouts never
  // coincide (one needs STOP, the other IDLE); start detect beats timeout.
  always_comb begin
    ptr_d      = ptr_q;
    high_d     = high_q;
    data_d     = data_q;
    rx_valid_d = 1'b0;
    sync_err_d = 1'b0;
    tmo_d      = tmo_q;
    if (good_stb) begin
      if (ptr_q) begin
        data_d     = {high_q, shift};
        rx_valid_d = 1'b1;
        ptr_d      = 1'b0;
      end else begin
        high_d = shift;
        ptr_d  = 1'b1;
      end
    end else if (bad_stb) begin
      ptr_d = 1'b0;
    end
    if (start_det || !ptr_q || !idle) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_MAX) begin
      tmo_d      = '0;
      sync_err_d = 1'b1;
      ptr_d      = 1'b0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Word-layer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= 1'b0;
      high_q     <= '0;
      data_q     <= '0;
      rx_valid_q <= 1'b0;
      sync_err_q <= 1'b0;
      tmo_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      high_q     <= high_d;
      data_q     <= data_d;
      rx_valid_q <= rx_valid_d;
      sync_err_q <= sync_err_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.Rx_Byte    = rx_byte;
  assign bus.Byte_Valid = byte_valid;
  assign bus.Rx_Data    = data_q;
  assign bus.Rx_Valid   = rx_valid_q;
  assign bus.Frame_Err  = frame_err;
  assign bus.Sync_Err   = sync_err_q;
  assign bus.Busy       = busy;
  assign dbg_state_o    = state;

endmodule
